// File: rtl/lc3_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : lc3_mem_responder
// Purpose  : LC-3 memory-side responder (MAR/MDR/RAM) with fixed-latency
//            read/write engine, memR ready pulse and program preload port.
// Revision : 1.0  initial release
// ============================================================================
module lc3_mem_responder #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] busIn,
    input  logic              ldMAR,
    input  logic              ldMDR,
    input  logic [1:0]        selMDR,
    input  logic              memWE,
    input  logic [DATA_W-1:0] MARSpcIn,
    input  logic [DATA_W-1:0] MDRSpcIn,
    input  logic              ldMARSpcIn,
    output logic [DATA_W-1:0] marOut,
    output logic [DATA_W-1:0] mdrOut,
    output logic              memR,
    output logic              busy,
    output logic              addrErr,
    output logic              spcDrop
);

    localparam int c_LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int c_CNT_W   = (c_LAT_MAX > 1) ? $clog2(c_LAT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_RD_CNT = c_CNT_W'(RD_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_WR_CNT = c_CNT_W'(WR_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0]   r_mar, r_mdr, r_addr, r_data;
    logic                r_rd_lvl_q, r_we_q, r_memR, r_addr_err, r_spc_drop;
    logic                w_rd_lvl, w_rd_req, w_wr_req;
    logic                w_start, w_done, w_spc_wr, w_oor;
    logic [DATA_W-1:0]   w_rd_word;
    logic                w_unused_spc;
    logic [DATA_W-1:0]   r_mem [0:(1<<ADDR_W)-1];

    assign w_rd_lvl  = ldMDR & (selMDR == 2'b01);
    assign w_rd_req  = w_rd_lvl & ~r_rd_lvl_q;
    assign w_wr_req  = memWE & ~r_we_q;
    assign w_oor     = |(r_addr >> ADDR_W);
    assign w_rd_word = w_oor ? '0 : r_mem[r_addr[ADDR_W-1:0]];
    // Preload addresses wrap onto the implemented range; high bits are ignored.
    assign w_unused_spc = |(MARSpcIn >> ADDR_W);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_start     = 1'b0;
        w_done      = 1'b0;
        w_spc_wr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ldMARSpcIn) begin
                    w_spc_wr = 1'b1;
                end else if (w_wr_req) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_WR;
                    w_cnt_nxt   = c_WR_CNT;
                end else if (w_rd_req) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_RD;
                    w_cnt_nxt   = c_RD_CNT;
                end
            end
            S_RD, S_WR: begin
                if (r_cnt == '0) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_mar      <= '0;
            r_mdr      <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_rd_lvl_q <= 1'b0;
            r_we_q     <= 1'b0;
            r_memR     <= 1'b0;
            r_addr_err <= 1'b0;
            r_spc_drop <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rd_lvl_q <= w_rd_lvl;
            r_we_q     <= memWE;
            r_memR     <= w_done;
            r_addr_err <= w_done & w_oor;
            if (ldMARSpcIn && (r_state != S_IDLE))
                r_spc_drop <= 1'b1;
            if (ldMAR)
                r_mar <= busIn;
            // Read completion has priority over a same-cycle bus load of MDR.
            if (w_done && (r_state == S_RD))
                r_mdr <= w_rd_word;
            else if (ldMDR && (selMDR == 2'b00))
                r_mdr <= busIn;
            if (w_start) begin
                r_addr <= r_mar;
                r_data <= r_mdr;
            end
        end
    end

    // RAM is not cleared by reset; an access aborted by reset never commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (w_spc_wr)
                r_mem[MARSpcIn[ADDR_W-1:0]] <= MDRSpcIn;
            else if (w_done && (r_state == S_WR) && !w_oor)
                r_mem[r_addr[ADDR_W-1:0]] <= r_data;
        end
    end

    assign marOut  = r_mar;
    assign mdrOut  = r_mdr;
    assign memR    = r_memR;
    assign busy    = (r_state != S_IDLE);
    assign addrErr = r_addr_err;
    assign spcDrop = r_spc_drop;

endmodule
`default_nettype wire

// File: tb/tb_lc3_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3_mem_responder
// Purpose  : Directed self-checking bench with a response scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_lc3_mem_responder;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 2;
    localparam int WR_LAT = 2;

    logic              clk, reset;
    logic [DATA_W-1:0] busIn, MARSpcIn, MDRSpcIn;
    logic              ldMAR, ldMDR, memWE, ldMARSpcIn;
    logic [1:0]        selMDR;
    logic [DATA_W-1:0] marOut, mdrOut;
    logic              memR, busy, addrErr, spcDrop;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit                is_rd;
        logic [DATA_W-1:0] data;
        bit                err;
        int                lat;
    } exp_t;
    exp_t sb[$];

    lc3_mem_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
    ) dut (
        .clk(clk), .reset(reset), .busIn(busIn), .ldMAR(ldMAR), .ldMDR(ldMDR),
        .selMDR(selMDR), .memWE(memWE), .MARSpcIn(MARSpcIn), .MDRSpcIn(MDRSpcIn),
        .ldMARSpcIn(ldMARSpcIn), .marOut(marOut), .mdrOut(mdrOut), .memR(memR),
        .busy(busy), .addrErr(addrErr), .spcDrop(spcDrop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void expect_resp(input bit rd, input logic [DATA_W-1:0] d,
                                        input bit e, input int lat);
        exp_t x;
        x.is_rd = rd; x.data = d; x.err = e; x.lat = lat;
        sb.push_back(x);
    endfunction

    task automatic issue_read();
        ldMDR  = 1'b1;
        selMDR = 2'b01;
        step();
        ldMDR  = 1'b0;
        selMDR = 2'b00;
    endtask

    task automatic load_mar(input logic [DATA_W-1:0] v);
        busIn = v; ldMAR = 1'b1;
        step();
        ldMAR = 1'b0;
    endtask

    task automatic load_mdr(input logic [DATA_W-1:0] v);
        busIn = v; ldMDR = 1'b1; selMDR = 2'b00;
        step();
        ldMDR = 1'b0;
    endtask

    // Waits (bounded) for memR and checks it against the oldest scoreboard entry.
    task automatic collect(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (n < 8) begin
            step();
            n++;
            if (memR) break;
        end
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({tag, "_latency"}, n, e.lat);
        check({tag, "_addrErr"}, addrErr, e.err);
        if (e.is_rd) check({tag, "_mdr"}, mdrOut, e.data);
        step();
        check({tag, "_memR_pulse"}, memR, 1'b0);
        check({tag, "_addrErr_pulse"}, addrErr, 1'b0);
    endtask

    initial begin
        reset = 1'b0; busIn = '0; MARSpcIn = '0; MDRSpcIn = '0;
        ldMAR = 0; ldMDR = 0; selMDR = 2'b00; memWE = 0; ldMARSpcIn = 0;
        step(); step();
        check("rst_mar", marOut, 0);
        check("rst_mdr", mdrOut, 0);
        check("rst_memR", memR, 0);
        check("rst_busy", busy, 0);
        check("rst_addrErr", addrErr, 0);
        check("rst_spcDrop", spcDrop, 0);
        reset = 1'b1;

        // Preloads; the first one coincides with a read edge that must be dropped.
        ldMDR = 1'b1; selMDR = 2'b01;
        ldMARSpcIn = 1'b1; MARSpcIn = 16'h0005; MDRSpcIn = 16'h1234;
        step();
        check("spc_beats_rd_busy", busy, 0);
        MARSpcIn = 16'h0000; MDRSpcIn = 16'h7777; step();
        MARSpcIn = 16'h0010; MDRSpcIn = 16'h1111; step();
        MARSpcIn = 16'h0020; MDRSpcIn = 16'h3333; step();
        ldMARSpcIn = 1'b0; ldMDR = 1'b0; selMDR = 2'b00;
        step();
        check("spc_no_memR", memR, 0);
        check("spc_mar_untouched", marOut, 0);
        check("spc_mdr_untouched", mdrOut, 0);

        // Read back preloaded word.
        load_mar(16'h0005);
        check("mar_load", marOut, 16'h0005);
        expect_resp(1, 16'h1234, 0, RD_LAT);
        issue_read();
        collect("rd_05");

        // Held memWE issues exactly one write.
        load_mar(16'h00A0);
        load_mdr(16'hBEEF);
        check("mdr_bus_load", mdrOut, 16'hBEEF);
        memWE = 1'b1;
        expect_resp(0, '0, 0, WR_LAT);
        step();
        collect("wr_a0_held");
        step();
        check("wr_held_no_second", memR, 0);
        check("wr_held_not_busy", busy, 0);
        memWE = 1'b0;
        load_mdr(16'h0000);
        expect_resp(1, 16'hBEEF, 0, RD_LAT);
        issue_read();
        collect("rd_a0");

        // Out-of-range address.
        load_mar(16'h0100);
        expect_resp(1, 16'h0000, 1, RD_LAT);
        issue_read();
        collect("rd_oor");
        load_mdr(16'h5555);
        expect_resp(0, '0, 1, WR_LAT);
        memWE = 1'b1; step(); memWE = 1'b0;
        collect("wr_oor");
        load_mar(16'h0000);
        expect_resp(1, 16'h7777, 0, RD_LAT);
        issue_read();
        collect("rd_00_unchanged");

        // Simultaneous write and read edges: write wins, read dropped.
        load_mar(16'h0010);
        load_mdr(16'h2222);
        memWE = 1'b1; ldMDR = 1'b1; selMDR = 2'b01;
        expect_resp(0, '0, 0, WR_LAT);
        step();
        memWE = 1'b0; ldMDR = 1'b0; selMDR = 2'b00;
        collect("wr_rd_same");
        check("wr_rd_same_mdr_kept", mdrOut, 16'h2222);
        for (int i = 0; i < 3; i++) begin
            step();
            check("wr_rd_same_no_read", memR, 0);
        end
        expect_resp(1, 16'h2222, 0, RD_LAT);
        issue_read();
        collect("rd_10");

        // Preload while busy is dropped and flagged.
        load_mar(16'h0020);
        expect_resp(1, 16'h3333, 0, RD_LAT - 1);
        issue_read();
        ldMARSpcIn = 1'b1; MARSpcIn = 16'h0020; MDRSpcIn = 16'hDEAD;
        step();
        ldMARSpcIn = 1'b0;
        check("spcDrop_set", spcDrop, 1);
        collect("rd_20_spc");
        expect_resp(1, 16'h3333, 0, RD_LAT);
        issue_read();
        collect("rd_20_not_written");
        check("spcDrop_sticky", spcDrop, 1);

        // Reset on what would be the commit edge of a write.
        load_mar(16'h0005);
        load_mdr(16'hAAAA);
        memWE = 1'b1; step(); memWE = 1'b0;
        step();
        check("wr_busy_before_reset", busy, 1);
        reset = 1'b0;
        step();
        check("abort_memR", memR, 0);
        check("abort_busy", busy, 0);
        check("abort_mar", marOut, 0);
        check("abort_mdr", mdrOut, 0);
        check("abort_addrErr", addrErr, 0);
        check("abort_spcDrop", spcDrop, 0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_no_late_memR", memR, 0);
        end
        load_mar(16'h0005);
        expect_resp(1, 16'h1234, 0, RD_LAT);
        issue_read();
        collect("rd_05_after_abort");

        // ldMAR in the request cycle: the pre-load MAR is used.
        busIn = 16'h0010; ldMAR = 1'b1;
        expect_resp(1, 16'h1234, 0, RD_LAT);
        issue_read();
        ldMAR = 1'b0;
        check("mar_same_cycle", marOut, 16'h0010);
        collect("rd_same_cycle_mar");

        // ldMAR mid-read: data from latched address, marOut shows new value.
        expect_resp(1, 16'h2222, 0, RD_LAT - 1);
        issue_read();
        load_mar(16'h0005);
        check("mar_mid_read", marOut, 16'h0005);
        collect("rd_mid_mar");

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
